dac_hpf_scheduler: RTL

Time-multiplexes one shared `multiplier_18x18` (external, in the parent) across `N_DAC` DAC output lanes for their one-pole high-pass filter state updates. Each lane posts a request carrying its clamped (sample − state) difference and coefficient. The scheduler grants lanes round-robin, one multiplier issue per cycle, and returns the scaled state increment (delta) tagged with the lane index. It sits between the per-lane DAC datapaths and the multiplier, replacing one multiplier per lane.

---
 rtl/dac_hpf_pkg.sv | 33 +++
 rtl/dac_hpf_scheduler_rr_arbiter.sv | 48 ++++
 rtl/dac_hpf_scheduler.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dac_hpf_pkg.sv
// -----------------------------------------------------------------------------
// dac_hpf_pkg
// Shared constants and types for the DAC high-pass-filter multiplier scheduler:
// operand/product widths, the slice of the product that forms the state
// increment, the scheduler FSM state type and the operand-B packing helper.
// -----------------------------------------------------------------------------
package dac_hpf_pkg;

  localparam int N_DAC_DEFAULT = 8;

  localparam int DIFF_W  = 18;  // signed (sample - state)
  localparam int COEF_W  = 16;  // unsigned coefficient
  localparam int OPND_W  = 18;  // multiplier operand width
  localparam int DELTA_W = 32;  // state increment width
  localparam int PROD_W  = 36;  // multiplier product width

  // The increment is product bits [34:3]: the coefficient is pre-shifted left
  // by one in operand B, so this slice yields a signed 32-bit scaled value.
  localparam int DELTA_MSB = 34;
  localparam int DELTA_LSB = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } hpf_state_e;

  // Operand B is the coefficient as a positive signed 18-bit value, shifted by one.
  function automatic logic [OPND_W-1:0] coef_to_operand(input logic [COEF_W-1:0] coef);
    return {1'b0, coef, 1'b0};
  endfunction

endpackage

// File: rtl/dac_hpf_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Searches i_pend starting at i_ptr and
// wrapping modulo N; the first set bit wins.
//   i_pend  : request vector
//   i_ptr   : highest-priority lane index (0..N-1)
//   o_grant : one-hot grant (all zero when nothing pending)
//   o_idx   : index of the granted lane
//   o_valid : a grant was made
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_pend,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  logic [W:0] w_sum;

  // Scan from lowest priority to highest so the nearest pending lane is written last
  always_comb begin
    o_grant = {N{1'b0}};
    o_idx   = {W{1'b0}};
    o_valid = 1'b0;
    w_sum   = {(W+1){1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      w_sum = {1'b0, i_ptr} + (W+1)'(i);
      if (w_sum >= (W+1)'(N)) begin
        w_sum = w_sum - (W+1)'(N);
      end else begin
        w_sum = w_sum;
      end
      if (i_pend[w_sum[W-1:0]]) begin
        o_grant                = {N{1'b0}};
        o_grant[w_sum[W-1:0]]  = 1'b1;
        o_idx                  = w_sum[W-1:0];
        o_valid                = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/dac_hpf_scheduler.sv
// -----------------------------------------------------------------------------
// dac_hpf_scheduler
// Shares one external 18x18 multiplier among N_DAC lanes for their one-pole
// HPF state updates. Lanes post one-cycle requests; the scheduler issues one
// lane per cycle round-robin, captures that lane's operands, tracks the lane
// through the multiplier latency and returns delta = product[34:3] tagged
// with the lane index.
// Ports:
//   dataclk, reset        : clock, async active-high reset
//   sample_strobe         : frame start marker (only used for overrun detect)
//   hpf_req/diff/coef     : per-lane request pulse and packed operands
//   hpf_ack               : pulse in the cycle after a lane's operands are captured
//   mult_a/mult_b/mult_p  : registered operands to / product from the multiplier
//   delta_valid/delta/delta_lane : returned state increment
//   frame_busy/frame_done : activity flag and busy->idle pulse
//   frame_overrun/lane_overrun/overrun_clr : sticky overrun flags and clear
// -----------------------------------------------------------------------------
module dac_hpf_scheduler
  import dac_hpf_pkg::*;
#(
  parameter int N_DAC    = N_DAC_DEFAULT,
  parameter int MULT_LAT = 1,
  parameter int LANE_W   = $clog2(N_DAC)
) (
  input  logic                     dataclk,
  input  logic                     reset,
  input  logic                     sample_strobe,
  input  logic [N_DAC-1:0]         hpf_req,
  input  logic [N_DAC*DIFF_W-1:0]  hpf_diff,
  input  logic [N_DAC*COEF_W-1:0]  hpf_coef,
  output logic [N_DAC-1:0]         hpf_ack,
  output logic [OPND_W-1:0]        mult_a,
  output logic [OPND_W-1:0]        mult_b,
  input  logic [PROD_W-1:0]        mult_p,
  output logic                     delta_valid,
  output logic [DELTA_W-1:0]       delta,
  output logic [LANE_W-1:0]        delta_lane,
  output logic                     frame_busy,
  output logic                     frame_done,
  output logic                     frame_overrun,
  output logic [N_DAC-1:0]         lane_overrun,
  input  logic                     overrun_clr
);

  hpf_state_e          r_state, w_state_nxt;
  logic                w_done_nxt;
  logic [N_DAC-1:0]    r_pend;
  logic [LANE_W-1:0]   r_ptr;
  logic [N_DAC-1:0]    w_gnt;
  logic [LANE_W-1:0]   w_gnt_idx;
  logic                w_gnt_valid;
  logic [N_DAC-1:0]    r_ack;
  logic [OPND_W-1:0]   r_mult_a, r_mult_b;
  // Stage 0 travels with the operand registers; stages 1..MULT_LAT cover the multiplier.
  logic [MULT_LAT:0]   r_pipe_v;
  logic [LANE_W-1:0]   r_pipe_lane [MULT_LAT+1];
  logic                r_delta_valid;
  logic [DELTA_W-1:0]  r_delta;
  logic [LANE_W-1:0]   r_delta_lane;
  logic                r_frame_done;
  logic                r_frame_ovr;
  logic [N_DAC-1:0]    r_lane_ovr;
  logic [N_DAC-1:0]    w_lane_ovr_set;
  logic                w_frame_ovr_set;
  logic                w_pipe_busy;
  logic                w_unused;

  logic [DIFF_W-1:0]   w_diff [N_DAC];
  logic [COEF_W-1:0]   w_coef [N_DAC];

  for (genvar k = 0; k < N_DAC; k++) begin : g_lane
    assign w_diff[k] = hpf_diff[k*DIFF_W +: DIFF_W];
    assign w_coef[k] = hpf_coef[k*COEF_W +: COEF_W];
  end

  rr_arbiter #(.N(N_DAC), .W(LANE_W)) u_arb (
    .i_pend  (r_pend),
    .i_ptr   (r_ptr),
    .o_grant (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_valid (w_gnt_valid)
  );

  assign w_pipe_busy = |r_pipe_v;
  // A repeat request is only an overrun if the lane is not being issued this cycle.
  assign w_lane_ovr_set  = hpf_req & r_pend & ~w_gnt;
  assign w_frame_ovr_set = sample_strobe & (r_state != ST_IDLE);
  assign w_unused        = ^{mult_p[PROD_W-1], mult_p[DELTA_LSB-1:0]};

  // FSM state register
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: RUN while work remains to issue, DRAIN until the pipe empties
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|r_pend) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (((r_pend & ~w_gnt) == {N_DAC{1'b0}}) && (hpf_req == {N_DAC{1'b0}})) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (|r_pend) begin
          w_state_nxt = ST_RUN;
        end else if (!w_pipe_busy) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pending bits, round-robin pointer, operand capture and ack
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      r_pend   <= {N_DAC{1'b0}};
      r_ptr    <= {LANE_W{1'b0}};
      r_ack    <= {N_DAC{1'b0}};
      r_mult_a <= {OPND_W{1'b0}};
      r_mult_b <= {OPND_W{1'b0}};
    end else begin
      r_pend <= (r_pend & ~w_gnt) | hpf_req;
      r_ack  <= w_gnt;
      if (w_gnt_valid) begin
        r_ptr    <= (w_gnt_idx == LANE_W'(N_DAC - 1)) ? {LANE_W{1'b0}} : w_gnt_idx + LANE_W'(1);
        r_mult_a <= w_diff[w_gnt_idx];
        r_mult_b <= coef_to_operand(w_coef[w_gnt_idx]);
      end
    end
  end

  // Lane tag pipe alongside the multiplier, and delta retire register
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      r_pipe_v      <= {(MULT_LAT+1){1'b0}};
      for (int i = 0; i <= MULT_LAT; i++) begin
        r_pipe_lane[i] <= {LANE_W{1'b0}};
      end
      r_delta_valid <= 1'b0;
      r_delta       <= {DELTA_W{1'b0}};
      r_delta_lane  <= {LANE_W{1'b0}};
    end else begin
      r_pipe_v       <= {r_pipe_v[MULT_LAT-1:0], w_gnt_valid};
      r_pipe_lane[0] <= w_gnt_idx;
      for (int i = 1; i <= MULT_LAT; i++) begin
        r_pipe_lane[i] <= r_pipe_lane[i-1];
      end
      r_delta_valid <= r_pipe_v[MULT_LAT];
      if (r_pipe_v[MULT_LAT]) begin
        r_delta      <= mult_p[DELTA_MSB:DELTA_LSB];
        r_delta_lane <= r_pipe_lane[MULT_LAT];
      end
    end
  end

  // Frame-done pulse and sticky overrun flags (a coincident set beats the clear)
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      r_frame_done <= 1'b0;
      r_frame_ovr  <= 1'b0;
      r_lane_ovr   <= {N_DAC{1'b0}};
    end else begin
      r_frame_done <= w_done_nxt;
      if (overrun_clr) begin
        r_frame_ovr <= w_frame_ovr_set;
        r_lane_ovr  <= w_lane_ovr_set;
      end else begin
        r_frame_ovr <= r_frame_ovr | w_frame_ovr_set;
        r_lane_ovr  <= r_lane_ovr | w_lane_ovr_set;
      end
    end
  end

  assign hpf_ack       = r_ack;
  assign mult_a        = r_mult_a;
  assign mult_b        = r_mult_b;
  assign delta_valid   = r_delta_valid;
  assign delta         = r_delta;
  assign delta_lane    = r_delta_lane;
  assign frame_busy    = (r_state != ST_IDLE);
  assign frame_done    = r_frame_done;
  assign frame_overrun = r_frame_ovr;
  assign lane_overrun  = r_lane_ovr;

endmodule
